lsu_arb: RTL and testbench
==========================

LSU_ARB -- requirements
Module: lsu_arb

Interface
REQ-001: Parameter MAX_BURST, default 4: maximum consecutive acked accesses by one owner while the other master is waiting; legal range 1..15.
REQ-002: clk  input  1  single clock; all state updates on rising edge.
REQ-003: rst  input  1  reset, synchronous, active-high.
REQ-004: i_m0_req / i_m1_req  input  1 each  access request from master 0 (CPU) / master 1 (DMA/loader).
REQ-005: i_m0_we / i_m1_we  input  1 each  1 = word store, 0 = word load.
REQ-006: i_m0_lock / i_m1_lock  input  1 each  hold ownership for an atomic sequence.
REQ-007: i_m0_addr, i_m0_wdata, i_m1_addr, i_m1_wdata  input  32 each  byte address (word-aligned) and store data.
REQ-008: o_m0_ack / o_m1_ack  output  1 each  access performed this cycle.
REQ-009: o_m0_rdata / o_m1_rdata  output  32 each  load data, valid in ack cycle.
REQ-010: o_lsu_we, o_lsu_re  output  1 each  drive the LSU access port.
REQ-011: o_lsu_addr, o_lsu_wdata  output  32 each  drive the LSU access port.
REQ-012: i_lsu_rdata  input  32  combinational LSU read data.
REQ-013: o_grant  output  2  one-hot current owner (bit0 = m0, bit1 = m1), 2'b00 when idle.

Function
REQ-014: FSM states IDLE, OWN0, OWN1; o_grant SHALL equal 00/01/10 respectively.
REQ-015: IDLE, only mX requesting -> OWNX next cycle; neither -> stay IDLE.
REQ-016: IDLE, both requesting -> master indicated by 1-bit round-robin pointer; pointer resets to m0.
REQ-017: Pointer SHALL be set to favour the non-owner on every entry into OWN0/OWN1.
REQ-018: No ack in IDLE; latency from req rising in IDLE to ack is exactly 1 cycle.
REQ-019: In OWNX with i_mX_req=1: o_lsu_addr/wdata = master X values, o_lsu_we = i_mX_we, o_lsu_re = !i_mX_we, o_mX_ack = 1 same cycle.
REQ-020: In OWNX with i_mX_req=0: o_lsu_we = o_lsu_re = 0, no ack.
REQ-021: o_lsu_we and o_lsu_re SHALL never both be 1; both 0 whenever no ack is issued.
REQ-022: o_mX_rdata = i_lsu_rdata in mX ack cycles of a load; 32'd0 otherwise.
REQ-023: The non-owner's ack SHALL be 0; two acks in one cycle are prohibited.
REQ-024: 4-bit burst counter: cleared on every ownership change and on entry to IDLE; incremented per owner ack, saturating at MAX_BURST.
REQ-025: OWNX next state, first match wins:
  (a) i_mX_lock=1 -> stay OWNX.
  (b) other requesting and (i_mX_req=0 or counter+ack this cycle >= MAX_BURST) -> OWN other.
  (c) i_mX_req=0 and other idle -> IDLE.
  (d) otherwise -> stay OWNX.
REQ-026: While lock held, ownership SHALL persist indefinitely, including cycles with i_mX_req=0; the counter keeps saturating but does not preempt.
REQ-027: Direct OWN0<->OWN1 handover SHALL take zero idle cycles; the new owner is acked in the cycle after the last old-owner cycle.
REQ-028: Masters SHALL hold addr/we/wdata stable while req=1 and unacked; the arbiter does not register request payload.

Reset
REQ-029: While rst=1: o_lsu_we, o_lsu_re, both acks = 0; rdata outputs = 0; o_grant = 00 after the edge.
REQ-030: On the edge with rst=1: state -> IDLE, counter -> 0, pointer -> m0, regardless of state or lock; any in-flight access is dropped without ack.

Verification
REQ-031: m0 req load addr 0x2000 (RAM = 0x1234_5678) from IDLE -> o_grant=01 next cycle, o_m0_ack=1, o_lsu_re=1, o_m0_rdata=0x1234_5678.
REQ-032: Both req from IDLE after reset -> m0 owns first. m0 holds req with MAX_BURST=4 -> exactly 4 m0 acks, then o_grant=10 next cycle with no gap. m1 then gets 4 acks and returns to m0.
REQ-033: m1 owns with lock=1 and req toggling, m0 requesting for 20 cycles -> o_grant stays 10, m0 never acked. Lock drop -> handover to m0 next cycle.
REQ-034: m0 store 0xA5 to 0x7000 (LEDR) -> o_lsu_we=1 for exactly one ack cycle, addr 0x7000, wdata 0xA5. Req dropped -> o_grant=00 next cycle.
REQ-035: rst asserted in OWN1 mid-burst with lock=1 -> no ack and lsu we/re=0 in the rst cycle; then o_grant=00. Both req after -> m0 granted first.
REQ-036: Random dual-master traffic, 10k cycles -> we/re never both 1; never two acks in a cycle; waiting unlocked master acked within MAX_BURST+1 cycles.

Source files
------------

// File: rtl/lsu_arb.sv
// lsu_arb: two-master round-robin arbiter with burst limit and lock for a single LSU port
module lsu_arb #(
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_m0_req,
  input  logic        i_m0_we,
  input  logic        i_m0_lock,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_wdata,
  input  logic        i_m1_req,
  input  logic        i_m1_we,
  input  logic        i_m1_lock,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_wdata,
  output logic        o_m0_ack,
  output logic [31:0] o_m0_rdata,
  output logic        o_m1_ack,
  output logic [31:0] o_m1_rdata,
  output logic        o_lsu_we,
  output logic        o_lsu_re,
  output logic [31:0] o_lsu_addr,
  output logic [31:0] o_lsu_wdata,
  input  logic [31:0] i_lsu_rdata,
  output logic [1:0]  o_grant
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t     state, state_nx;
  logic       ptr;
  logic [3:0] cnt;
  logic [4:0] sum;
  logic       own0, own1, lim;
  assign own0 = state == OWN0;
  assign own1 = state == OWN1;
  assign o_m0_ack = own0 & i_m0_req & !rst;
  assign o_m1_ack = own1 & i_m1_req & !rst;
  assign sum = {1'b0, cnt} + {4'd0, o_m0_ack | o_m1_ack};
  assign lim = sum >= 5'(MAX_BURST);
  assign o_lsu_we = o_m0_ack ? i_m0_we : o_m1_ack & i_m1_we;
  assign o_lsu_re = o_m0_ack ? !i_m0_we : o_m1_ack & !i_m1_we;
  assign o_lsu_addr = own1 ? i_m1_addr : i_m0_addr;
  assign o_lsu_wdata = own1 ? i_m1_wdata : i_m0_wdata;
  assign o_m0_rdata = (o_m0_ack & !i_m0_we) ? i_lsu_rdata : '0;
  assign o_m1_rdata = (o_m1_ack & !i_m1_we) ? i_lsu_rdata : '0;
  assign o_grant = {own1, own0};
  // next owner: lock holds, waiting master takes over on idle owner or exhausted burst
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE: state_nx = (i_m0_req & i_m1_req) ? (ptr ? OWN1 : OWN0) : i_m0_req ? OWN0 : i_m1_req ? OWN1 : IDLE;
      OWN0: state_nx = i_m0_lock ? OWN0 : (i_m1_req & (!i_m0_req | lim)) ? OWN1 : (!i_m0_req & !i_m1_req) ? IDLE : OWN0;
      OWN1: state_nx = i_m1_lock ? OWN1 : (i_m0_req & (!i_m1_req | lim)) ? OWN0 : (!i_m1_req & !i_m0_req) ? IDLE : OWN1;
      default: state_nx = IDLE;
    endcase
  end
  // state, saturating burst count cleared on ownership change, pointer favouring the non-owner
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      ptr <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= (state_nx != state || state_nx == IDLE) ? 4'd0 : lim ? 4'(MAX_BURST) : sum[3:0];
      if (state_nx == OWN0 && state != OWN0) ptr <= 1'b1;
      else if (state_nx == OWN1 && state != OWN1) ptr <= 1'b0;
    end
  end
endmodule

// File: tb/tb_lsu_arb.sv
// tb_lsu_arb: directed and random checks of the two-master LSU arbiter
module tb_lsu_arb;
  localparam int MB = 4;
  logic clk = 0, rst = 1;
  logic m0_req = 0, m0_we = 0, m0_lock = 0, m1_req = 0, m1_we = 0, m1_lock = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic m0_ack, m1_ack, lsu_we, lsu_re;
  logic [31:0] m0_rdata, m1_rdata, lsu_addr, lsu_wdata, lsu_rdata;
  logic [1:0] grant;
  int compared = 0, mismatched = 0;
  always #5 clk = ~clk;
  assign lsu_rdata = (lsu_addr == 32'h2000) ? 32'h1234_5678 : lsu_addr ^ 32'hDEAD_0000;
  lsu_arb #(.MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_lock(m0_lock), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
    .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_lock(m1_lock), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
    .o_m0_ack(m0_ack), .o_m0_rdata(m0_rdata), .o_m1_ack(m1_ack), .o_m1_rdata(m1_rdata),
    .o_lsu_we(lsu_we), .o_lsu_re(lsu_re), .o_lsu_addr(lsu_addr), .o_lsu_wdata(lsu_wdata),
    .i_lsu_rdata(lsu_rdata), .o_grant(grant)
  );
  task automatic cyc();
    @(negedge clk);
  endtask
  task automatic go_idle();
    m0_req = 0; m1_req = 0; m0_lock = 0; m1_lock = 0;
    cyc(); cyc(); #1;
    compared++;
    if (grant !== 2'b00) begin mismatched++; $display("FAIL idle_grant got %b want 00", grant); end
  endtask
  task automatic test_reset();
    rst = 1; m0_req = 1; m1_req = 1;
    cyc(); cyc(); #1;
    compared++;
    if ({grant, m0_ack, m1_ack, lsu_we, lsu_re} !== 6'b0) begin mismatched++; $display("FAIL reset_outs got %b want 000000", {grant, m0_ack, m1_ack, lsu_we, lsu_re}); end
    compared++;
    if ({m0_rdata, m1_rdata} !== 64'd0) begin mismatched++; $display("FAIL reset_rdata got %h want 0", {m0_rdata, m1_rdata}); end
    m0_req = 0; m1_req = 0;
    cyc(); rst = 0;
  endtask
  task automatic test_load();
    cyc(); m0_req = 1; m0_we = 0; m0_addr = 32'h2000; #1;
    compared++;
    if ({grant, m0_ack, lsu_re} !== 4'b0000) begin mismatched++; $display("FAIL load_idle got %b want 0000", {grant, m0_ack, lsu_re}); end
    cyc(); #1;
    compared++;
    if ({grant, m0_ack, m1_ack, lsu_re, lsu_we} !== 6'b011010) begin mismatched++; $display("FAIL load_ack got %b want 011010", {grant, m0_ack, m1_ack, lsu_re, lsu_we}); end
    compared++;
    if (m0_rdata !== 32'h1234_5678) begin mismatched++; $display("FAIL load_rdata got %h want 12345678", m0_rdata); end
    compared++;
    if (lsu_addr !== 32'h2000) begin mismatched++; $display("FAIL load_addr got %h want 2000", lsu_addr); end
    go_idle();
  endtask
  task automatic test_store();
    cyc(); m0_req = 1; m0_we = 1; m0_addr = 32'h7000; m0_wdata = 32'hA5;
    cyc(); #1;
    compared++;
    if ({grant, m0_ack, lsu_we, lsu_re} !== 5'b01110) begin mismatched++; $display("FAIL store_ack got %b want 01110", {grant, m0_ack, lsu_we, lsu_re}); end
    compared++;
    if ({lsu_addr, lsu_wdata} !== {32'h7000, 32'hA5}) begin mismatched++; $display("FAIL store_bus got %h want 00007000000000a5", {lsu_addr, lsu_wdata}); end
    compared++;
    if (m0_rdata !== 32'd0) begin mismatched++; $display("FAIL store_rdata got %h want 0", m0_rdata); end
    cyc(); m0_req = 0; #1;
    compared++;
    if ({grant, m0_ack, lsu_we, lsu_re} !== 5'b01000) begin mismatched++; $display("FAIL store_noreq got %b want 01000", {grant, m0_ack, lsu_we, lsu_re}); end
    cyc(); #1;
    compared++;
    if (grant !== 2'b00) begin mismatched++; $display("FAIL store_idle got %b want 00", grant); end
    m0_we = 0;
  endtask
  task automatic test_burst();
    test_reset();
    cyc(); m0_req = 1; m1_req = 1; m0_addr = 32'h2000; m1_addr = 32'h3000; #1;
    compared++;
    if (grant !== 2'b00) begin mismatched++; $display("FAIL burst_idle got %b want 00", grant); end
    for (int i = 0; i < MB; i++) begin
      cyc(); #1;
      compared++;
      if ({grant, m0_ack, m1_ack} !== 4'b0110) begin mismatched++; $display("FAIL burst_m0 cycle %0d got %b want 0110", i, {grant, m0_ack, m1_ack}); end
    end
    for (int i = 0; i < MB; i++) begin
      cyc(); #1;
      compared++;
      if ({grant, m0_ack, m1_ack} !== 4'b1001) begin mismatched++; $display("FAIL burst_m1 cycle %0d got %b want 1001", i, {grant, m0_ack, m1_ack}); end
      compared++;
      if (m1_rdata !== 32'hDEAD_3000) begin mismatched++; $display("FAIL burst_m1_rdata got %h want dead3000", m1_rdata); end
    end
    cyc(); #1;
    compared++;
    if ({grant, m0_ack} !== 3'b011) begin mismatched++; $display("FAIL burst_back got %b want 011", {grant, m0_ack}); end
    go_idle();
  endtask
  task automatic test_lock();
    cyc(); m1_req = 1; m1_lock = 1;
    cyc(); m0_req = 1; #1;
    compared++;
    if ({grant, m1_ack} !== 3'b101) begin mismatched++; $display("FAIL lock_own got %b want 101", {grant, m1_ack}); end
    for (int i = 0; i < 20; i++) begin
      cyc(); m1_req = i[0]; #1;
      compared++;
      if ({grant, m0_ack, m1_ack} !== {3'b100, i[0]}) begin mismatched++; $display("FAIL lock_hold cycle %0d got %b want %b", i, {grant, m0_ack, m1_ack}, {3'b100, i[0]}); end
    end
    cyc(); m1_lock = 0; m1_req = 0; #1;
    compared++;
    if (grant !== 2'b10) begin mismatched++; $display("FAIL lock_drop got %b want 10", grant); end
    cyc(); #1;
    compared++;
    if ({grant, m0_ack} !== 3'b011) begin mismatched++; $display("FAIL lock_handover got %b want 011", {grant, m0_ack}); end
    go_idle();
  endtask
  task automatic test_rst_lock();
    cyc(); m1_req = 1; m1_lock = 1; m1_we = 0;
    cyc(); m0_req = 1; #1;
    compared++;
    if ({grant, m1_ack} !== 3'b101) begin mismatched++; $display("FAIL rstlock_own got %b want 101", {grant, m1_ack}); end
    cyc(); rst = 1; #1;
    compared++;
    if ({m0_ack, m1_ack, lsu_we, lsu_re} !== 4'b0000) begin mismatched++; $display("FAIL rstlock_quiet got %b want 0000", {m0_ack, m1_ack, lsu_we, lsu_re}); end
    compared++;
    if (m1_rdata !== 32'd0) begin mismatched++; $display("FAIL rstlock_rdata got %h want 0", m1_rdata); end
    cyc(); rst = 0; #1;
    compared++;
    if ({grant, m0_ack, m1_ack} !== 4'b0000) begin mismatched++; $display("FAIL rstlock_idle got %b want 0000", {grant, m0_ack, m1_ack}); end
    cyc(); #1;
    compared++;
    if ({grant, m0_ack} !== 3'b011) begin mismatched++; $display("FAIL rstlock_m0first got %b want 011", {grant, m0_ack}); end
    go_idle();
  endtask
  task automatic test_random();
    int w0 = 0, w1 = 0;
    logic a0 = 0, a1 = 0;
    for (int i = 0; i < 10000; i++) begin
      cyc();
      if (a0 || !m0_req) begin m0_req = $urandom_range(0, 3) != 0; m0_we = $urandom_range(0, 1) != 0; m0_addr = $urandom & 32'hFFFC; end
      if (a1 || !m1_req) begin m1_req = $urandom_range(0, 3) != 0; m1_we = $urandom_range(0, 1) != 0; m1_addr = $urandom & 32'hFFFC; end
      #1;
      compared++;
      if (lsu_we && lsu_re) begin mismatched++; $display("FAIL rnd_we_re cycle %0d got 11 want not both", i); end
      compared++;
      if (m0_ack && m1_ack) begin mismatched++; $display("FAIL rnd_two_acks cycle %0d got 11 want not both", i); end
      w0 = (m0_req && !m0_ack) ? w0 + 1 : 0;
      w1 = (m1_req && !m1_ack) ? w1 + 1 : 0;
      compared++;
      if (w0 > MB + 1 || w1 > MB + 1) begin mismatched++; $display("FAIL rnd_wait cycle %0d got %0d/%0d want <= %0d", i, w0, w1, MB + 1); end
      a0 = m0_ack; a1 = m1_ack;
    end
    go_idle();
  endtask
  initial begin
    test_reset();
    test_load();
    test_store();
    test_burst();
    test_lock();
    test_rst_lock();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
